// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: RISC-V load/store size
// encodings, the default word-address width, the registered load context
// and the access-legality check used by the aligner.
package dmem_pkg;

  localparam int unsigned DMEM_ADDR_W = 15;

  // RISC-V funct3 encodings for loads/stores
  localparam logic [2:0] MEMOP_B  = 3'b000;
  localparam logic [2:0] MEMOP_H  = 3'b001;
  localparam logic [2:0] MEMOP_W  = 3'b010;
  localparam logic [2:0] MEMOP_BU = 3'b100;
  localparam logic [2:0] MEMOP_HU = 3'b101;

  // Load formatting context captured at the grant edge
  typedef struct packed {
    logic [2:0] memop;
    logic [1:0] off;
  } ld_ctx_t;

  // 1 when the access is misaligned or uses an encoding illegal for its direction
  function automatic logic memop_bad(input logic we, input logic [2:0] memop,
                                     input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    case (memop)
      MEMOP_B:  bad = 1'b0;
      MEMOP_H:  bad = off[0];
      MEMOP_W:  bad = |off;
      MEMOP_BU: bad = we;
      MEMOP_HU: bad = we | off[0];
      default:  bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_align.sv
// Combinational sub-word aligner.
// Store side: st_we/st_off/st_memop/st_wdata -> byteena_c, data_c, err_c
//   (lane enables, lane-replicated write data, illegal-access flag).
// Load side: ld_off/ld_memop/ld_word -> rdata_c (extracted and extended).
module dmem_align
  import dmem_pkg::*;
(
  input  logic        st_we,
  input  logic [1:0]  st_off,
  input  logic [2:0]  st_memop,
  input  logic [31:0] st_wdata,
  output logic [3:0]  byteena_c,
  output logic [31:0] data_c,
  output logic        err_c,
  input  logic [1:0]  ld_off,
  input  logic [2:0]  ld_memop,
  input  logic [31:0] ld_word,
  output logic [31:0] rdata_c
);

  logic [31:0] ld_shift;

  // Store lane selection; data is replicated so every lane carries the value
  always_comb begin
    err_c     = memop_bad(st_we, st_memop, st_off);
    byteena_c = 4'b0000;
    data_c    = st_wdata;
    case (st_memop[1:0])
      2'b00: begin
        byteena_c = 4'b0001 << st_off;
        data_c    = {4{st_wdata[7:0]}};
      end
      2'b01: begin
        byteena_c = 4'b0011 << st_off;
        data_c    = {2{st_wdata[15:0]}};
      end
      default: byteena_c = 4'b1111;
    endcase
    if (err_c) byteena_c = 4'b0000;
  end

  // Load extraction: bring the addressed lane down to bit 0, then extend
  always_comb begin
    ld_shift = ld_word >> {ld_off, 3'b000};
    case (ld_memop)
      MEMOP_B:  rdata_c = {{24{ld_shift[7]}}, ld_shift[7:0]};
      MEMOP_BU: rdata_c = {24'd0, ld_shift[7:0]};
      MEMOP_H:  rdata_c = {{16{ld_shift[15]}}, ld_shift[15:0]};
      MEMOP_HU: rdata_c = {16'd0, ld_shift[15:0]};
      default:  rdata_c = ld_shift;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the CPU load/store unit and a DMA/debug port.
// CPU side: cpu_req/we/memop/addr/wdata in; cpu_gnt (comb), cpu_rvalid,
//   cpu_rdata, cpu_err out (one cycle after grant).
// DMA side: dma_req/we/addr/be/wdata in; dma_gnt (comb), dma_rvalid,
//   dma_rdata out.
// Memory side: mem_wraddress/rdaddress/wren/byteena/data out (comb), mem_q in.
// CPU has priority; after STARVE_MAX CPU grants with DMA waiting, DMA wins.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W     = DMEM_ADDR_W,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [2:0]        cpu_memop,
  input  logic [ADDR_W+1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_err,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [3:0]        dma_be,
  input  logic [31:0]       dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [31:0]       dma_rdata,
  output logic [ADDR_W-1:0] mem_wraddress,
  output logic [ADDR_W-1:0] mem_rdaddress,
  output logic              mem_wren,
  output logic [3:0]        mem_byteena,
  output logic [31:0]       mem_data,
  input  logic [31:0]       mem_q
);

  localparam int unsigned STARVE_W = 4;
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                cpu_rvalid_q, cpu_rvalid_d;
  logic                cpu_err_q, cpu_err_d;
  logic                dma_rvalid_q, dma_rvalid_d;
  logic [31:0]         dma_rdata_q, dma_rdata_d;
  logic [31:0]         ld_word_q, ld_word_d;
  ld_ctx_t             ld_ctx_q, ld_ctx_d;

  logic [3:0]          st_byteena;
  logic [31:0]         st_data;
  logic                st_err;
  logic                cpu_ld_go;
  logic [ADDR_W-1:0]   mem_addr;

  dmem_align u_align (
    .st_we     (cpu_we),
    .st_off    (cpu_addr[1:0]),
    .st_memop  (cpu_memop),
    .st_wdata  (cpu_wdata),
    .byteena_c (st_byteena),
    .data_c    (st_data),
    .err_c     (st_err),
    .ld_off    (ld_ctx_q.off),
    .ld_memop  (ld_ctx_q.memop),
    .ld_word   (ld_word_q),
    .rdata_c   (cpu_rdata)
  );

  // Grant: CPU first unless DMA has waited out its starvation budget
  always_comb begin
    cpu_gnt = cpu_req && !(dma_req && (starve_q == STARVE_LIM));
    dma_gnt = dma_req && !cpu_gnt;
  end

  // Memory port steering; illegal CPU accesses are granted but issue nothing
  always_comb begin
    mem_addr    = '0;
    mem_wren    = 1'b0;
    mem_byteena = 4'b0000;
    mem_data    = 32'd0;
    if (cpu_gnt && !st_err) begin
      mem_addr    = cpu_addr[ADDR_W+1:2];
      mem_wren    = cpu_we;
      mem_byteena = cpu_we ? st_byteena : 4'b0000;
      mem_data    = cpu_we ? st_data : 32'd0;
    end else if (dma_gnt) begin
      mem_addr    = dma_addr;
      mem_wren    = dma_we;
      mem_byteena = dma_we ? dma_be : 4'b0000;
      mem_data    = dma_wdata;
    end
  end

  assign mem_wraddress = mem_addr;
  assign mem_rdaddress = mem_addr;

  // Response capture and starvation tracking
  always_comb begin
    cpu_ld_go    = cpu_gnt && !cpu_we && !st_err;
    cpu_rvalid_d = cpu_ld_go;
    cpu_err_d    = cpu_gnt && st_err;
    ld_ctx_d     = ld_ctx_q;
    ld_word_d    = ld_word_q;
    if (cpu_ld_go) begin
      ld_ctx_d.memop = cpu_memop;
      ld_ctx_d.off   = cpu_addr[1:0];
      ld_word_d      = mem_q;
    end
    dma_rvalid_d = dma_gnt && !dma_we;
    dma_rdata_d  = dma_rvalid_d ? mem_q : dma_rdata_q;
    starve_d     = starve_q;
    if (!dma_req || dma_gnt) begin
      starve_d = '0;
    end else if (cpu_gnt && (starve_q != STARVE_LIM)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      starve_q     <= '0;
      cpu_rvalid_q <= 1'b0;
      cpu_err_q    <= 1'b0;
      dma_rvalid_q <= 1'b0;
      dma_rdata_q  <= 32'd0;
      ld_word_q    <= 32'd0;
      ld_ctx_q     <= '0;
    end else begin
      starve_q     <= starve_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      cpu_err_q    <= cpu_err_d;
      dma_rvalid_q <= dma_rvalid_d;
      dma_rdata_q  <= dma_rdata_d;
      ld_word_q    <= ld_word_d;
      ld_ctx_q     <= ld_ctx_d;
    end
  end

  assign cpu_rvalid = cpu_rvalid_q;
  assign cpu_err    = cpu_err_q;
  assign dma_rvalid = dma_rvalid_q;
  assign dma_rdata  = dma_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a byte-addressed reference memory plus a
// grant/starvation model predict every grant, memory strobe and response.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  localparam int AW         = 15;
  localparam int STARVE_MAX = 4;

  logic          clock = 1'b0;
  logic          resetn;
  logic          cpu_req, cpu_we;
  logic [2:0]    cpu_memop;
  logic [AW+1:0] cpu_addr;
  logic [31:0]   cpu_wdata;
  logic          cpu_gnt, cpu_rvalid, cpu_err;
  logic [31:0]   cpu_rdata;
  logic          dma_req, dma_we;
  logic [AW-1:0] dma_addr;
  logic [3:0]    dma_be;
  logic [31:0]   dma_wdata;
  logic          dma_gnt, dma_rvalid;
  logic [31:0]   dma_rdata;
  logic [AW-1:0] mem_wraddress, mem_rdaddress;
  logic          mem_wren;
  logic [3:0]    mem_byteena;
  logic [31:0]   mem_data, mem_q;

  always #5 clock = ~clock;

  dmem_arbiter #(.ADDR_W(AW), .STARVE_MAX(STARVE_MAX)) dut (
    .clock(clock), .resetn(resetn),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_memop(cpu_memop),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt),
    .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_be(dma_be),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
    .dma_rdata(dma_rdata), .mem_wraddress(mem_wraddress),
    .mem_rdaddress(mem_rdaddress), .mem_wren(mem_wren),
    .mem_byteena(mem_byteena), .mem_data(mem_data), .mem_q(mem_q)
  );

  // Memory instance model: byte-enabled write on the edge, combinational read
  logic [31:0] mem [0:(1<<AW)-1];
  logic        mem_init = 1'b0;
  assign mem_q = mem[mem_rdaddress];
  always @(posedge clock) begin
    if (!mem_init) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= 32'd0;
      mem_init <= 1'b1;
    end else if (mem_wren) begin
      for (int i = 0; i < 4; i++)
        if (mem_byteena[i]) mem[mem_wraddress][8*i +: 8] <= mem_data[8*i +: 8];
    end
  end

  // Reference state
  logic [7:0]  ref_bytes [0:(1<<(AW+2))-1];
  int          ref_starve;
  logic        exp_crv, exp_cerr, exp_drv;
  logic [31:0] exp_crd, exp_drd;
  logic        obs_cgnt, obs_dgnt, mdl_cgnt, mdl_dgnt;
  int          ntests = 0;
  int          nfail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Access is legal only for defined sizes at naturally aligned addresses
  function automatic logic cpu_bad(input logic we, input logic [2:0] op, input logic [16:0] a);
    int sz;
    logic ok_op;
    ok_op = we ? (op inside {3'd0, 3'd1, 3'd2}) : (op inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (!ok_op) return 1'b1;
    sz = 1 << op[1:0];
    return (int'(a) % sz) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [16:0] a, input logic [2:0] op);
    int sz;
    logic [31:0] v;
    sz = 1 << op[1:0];
    v = 32'd0;
    for (int i = 0; i < sz; i++) v = v | (32'(ref_bytes[int'(a) + i]) << (8 * i));
    if (!op[2] && sz == 1 && v[7])  v = v | 32'hFFFF_FF00;
    if (!op[2] && sz == 2 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  // One clock cycle: drive at edge+1, check combinational side at negedge,
  // advance the model at the edge, check responses at edge+1.
  task automatic cyc(input logic creq, input logic cwe, input logic [2:0] cop,
                     input logic [16:0] caddr, input logic [31:0] cwd,
                     input logic dreq, input logic dwe, input logic [14:0] daddr,
                     input logic [3:0] dbe, input logic [31:0] dwd);
    logic eg_c, eg_d, bad, exp_wren;
    logic [14:0] exp_addr;
    int sz, base;
    cpu_req = creq; cpu_we = cwe; cpu_memop = cop; cpu_addr = caddr; cpu_wdata = cwd;
    dma_req = dreq; dma_we = dwe; dma_addr = daddr; dma_be = dbe; dma_wdata = dwd;
    eg_c = creq && !(dreq && ref_starve == STARVE_MAX);
    eg_d = dreq && !eg_c;
    bad  = cpu_bad(cwe, cop, caddr);
    exp_wren = (eg_c && cwe && !bad) || (eg_d && dwe);
    exp_addr = eg_c ? caddr[16:2] : daddr;
    #4;
    chk("cpu_gnt", 32'(cpu_gnt), 32'(eg_c));
    chk("dma_gnt", 32'(dma_gnt), 32'(eg_d));
    chk("mem_wren", 32'(mem_wren), 32'(exp_wren));
    if ((eg_c && !bad) || eg_d) begin
      chk("mem_wraddress", 32'(mem_wraddress), 32'(exp_addr));
      chk("mem_rdaddress", 32'(mem_rdaddress), 32'(exp_addr));
    end else if (!eg_c) begin
      chk("idle_addr", 32'(mem_wraddress), 32'd0);
      chk("idle_byteena", 32'(mem_byteena), 32'd0);
    end
    obs_cgnt = cpu_gnt; obs_dgnt = dma_gnt; mdl_cgnt = eg_c; mdl_dgnt = eg_d;
    @(posedge clock);
    exp_crv = 1'b0; exp_cerr = 1'b0; exp_drv = 1'b0;
    if (eg_c) begin
      sz = 1 << cop[1:0];
      base = int'(caddr);
      if (bad) begin
        exp_cerr = 1'b1;
      end else if (cwe) begin
        for (int i = 0; i < sz; i++) ref_bytes[base + i] = cwd[8*i +: 8];
      end else begin
        exp_crv = 1'b1;
        exp_crd = ref_load(caddr, cop);
      end
    end
    if (eg_d) begin
      base = 4 * int'(daddr);
      if (dwe) begin
        for (int i = 0; i < 4; i++) if (dbe[i]) ref_bytes[base + i] = dwd[8*i +: 8];
      end else begin
        exp_drv = 1'b1;
        for (int i = 0; i < 4; i++) exp_drd[8*i +: 8] = ref_bytes[base + i];
      end
    end
    if (!dreq || eg_d) ref_starve = 0;
    else if (eg_c && ref_starve < STARVE_MAX) ref_starve++;
    #1;
    chk("cpu_rvalid", 32'(cpu_rvalid), 32'(exp_crv));
    chk("cpu_err", 32'(cpu_err), 32'(exp_cerr));
    chk("dma_rvalid", 32'(dma_rvalid), 32'(exp_drv));
    if (exp_crv) chk("cpu_rdata", cpu_rdata, exp_crd);
    if (exp_drv) chk("dma_rdata", dma_rdata, exp_drd);
  endtask

  task automatic cpu_op(input logic we, input logic [2:0] op, input logic [16:0] a,
                        input logic [31:0] d);
    cyc(1'b1, we, op, a, d, 1'b0, 1'b0, 15'd0, 4'd0, 32'd0);
  endtask

  task automatic dma_op(input logic we, input logic [14:0] a, input logic [3:0] be,
                        input logic [31:0] d);
    cyc(1'b0, 1'b0, 3'd0, 17'd0, 32'd0, 1'b1, we, a, be, d);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 3'd0, 17'd0, 32'd0, 1'b0, 1'b0, 15'd0, 4'd0, 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cpu_rvalid"}, 32'(cpu_rvalid), 32'd0);
    chk({tag, "_cpu_err"}, 32'(cpu_err), 32'd0);
    chk({tag, "_dma_rvalid"}, 32'(dma_rvalid), 32'd0);
    chk({tag, "_cpu_rdata"}, cpu_rdata, 32'd0);
    chk({tag, "_dma_rdata"}, dma_rdata, 32'd0);
    chk({tag, "_mem_wren"}, 32'(mem_wren), 32'd0);
  endtask

  initial begin
    logic        creq, cwe, dreq, dwe;
    logic [2:0]  cop;
    logic [16:0] caddr;
    logic [31:0] cwd, dwd;
    logic [14:0] daddr;
    logic [3:0]  dbe;
    logic [9:0]  pat;

    resetn = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_memop = 3'd0; cpu_addr = '0; cpu_wdata = 32'd0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_be = 4'd0; dma_wdata = 32'd0;
    for (int i = 0; i < (1 << (AW + 2)); i++) ref_bytes[i] = 8'd0;
    ref_starve = 0;
    exp_crd = 32'd0; exp_drd = 32'd0;
    #2;
    chk_all_zero("reset");
    repeat (2) @(posedge clock);
    @(negedge clock) resetn = 1'b1;
    @(posedge clock);
    #1;

    // Sub-word stores and loads
    cpu_op(1'b1, MEMOP_W, 17'h100, 32'h1122_3344);
    cpu_op(1'b0, MEMOP_B, 17'h103, 32'd0);
    chk("lb_0x103", cpu_rdata, 32'h0000_0011);
    cpu_op(1'b0, MEMOP_H, 17'h102, 32'd0);
    chk("lh_0x102", cpu_rdata, 32'h0000_1122);
    cpu_op(1'b1, MEMOP_B, 17'h101, 32'h0000_0080);
    cpu_op(1'b0, MEMOP_B, 17'h101, 32'd0);
    chk("lb_0x101", cpu_rdata, 32'hFFFF_FF80);
    cpu_op(1'b0, MEMOP_BU, 17'h101, 32'd0);
    chk("lbu_0x101", cpu_rdata, 32'h0000_0080);
    cpu_op(1'b0, MEMOP_HU, 17'h100, 32'd0);
    cpu_op(1'b1, MEMOP_H, 17'h106, 32'hFFFF_BEEF);
    cpu_op(1'b0, MEMOP_W, 17'h104, 32'd0);

    // Misaligned / illegal accesses
    cpu_op(1'b0, MEMOP_W, 17'h102, 32'd0);
    chk("lw_mis_err", 32'(cpu_err), 32'd1);
    cpu_op(1'b1, MEMOP_W, 17'h200, 32'hCAFE_F00D);
    cpu_op(1'b1, MEMOP_H, 17'h201, 32'h0000_BEEF);
    cpu_op(1'b1, MEMOP_BU, 17'h200, 32'h0000_0011);
    cpu_op(1'b0, 3'b011, 17'h200, 32'd0);
    cpu_op(1'b0, MEMOP_W, 17'h200, 32'd0);
    chk("word_0x80_kept", cpu_rdata, 32'hCAFE_F00D);

    // Reset while a load is in flight
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_memop = MEMOP_W; cpu_addr = 17'h100;
    dma_req = 1'b0;
    #4;
    chk("rst_load_gnt", 32'(cpu_gnt), 32'd1);
    #2 resetn = 1'b0;
    cpu_req = 1'b0;
    #1;
    chk_all_zero("rst_held");
    @(posedge clock);
    #1;
    chk("rst_rvalid_dropped", 32'(cpu_rvalid), 32'd0);
    @(negedge clock) resetn = 1'b1;
    ref_starve = 0;
    @(posedge clock);
    #1;
    chk("post_rst_rvalid", 32'(cpu_rvalid), 32'd0);

    // Arbitration under continuous contention
    pat = '0;
    for (int k = 0; k < 10; k++) begin
      cyc(1'b1, 1'b0, MEMOP_W, 17'(4 * k), 32'd0, 1'b1, 1'b0, 15'(k), 4'd0, 32'd0);
      if (k == 0) chk("both_req_cpu_first", 32'(obs_cgnt), 32'd1);
      pat[k] = obs_dgnt;
    end
    chk("starve_pattern", 32'(pat), 32'(10'b10_0001_0000));
    idle();

    // DMA path, partial enables and empty enables
    dma_op(1'b1, 15'd5, 4'b0101, 32'hDEAD_BEEF);
    dma_op(1'b0, 15'd5, 4'b0000, 32'd0);
    chk("dma_partial", dma_rdata, 32'h00AD_00EF);
    idle();
    dma_op(1'b1, 15'd5, 4'b0000, 32'hFFFF_FFFF);
    dma_op(1'b0, 15'd5, 4'b0000, 32'd0);
    chk("dma_be0_noop", dma_rdata, 32'h00AD_00EF);

    // Write then immediate read from the other port
    dma_op(1'b1, 15'd7, 4'b1111, 32'hA5A5_A5A5);
    cpu_op(1'b0, MEMOP_W, 17'h1C, 32'd0);
    chk("fwd_dma_to_cpu", cpu_rdata, 32'hA5A5_A5A5);
    cpu_op(1'b1, MEMOP_B, 17'h1E, 32'h0000_0042);
    dma_op(1'b0, 15'd7, 4'b0000, 32'd0);
    chk("fwd_cpu_to_dma", dma_rdata, 32'hA542_A5A5);

    // Randomized traffic; requests held until granted
    creq = 1'b0; dreq = 1'b0;
    cwe = 1'b0; cop = 3'd0; caddr = '0; cwd = 32'd0;
    dwe = 1'b0; daddr = '0; dbe = 4'd0; dwd = 32'd0;
    for (int n = 0; n < 3000; n++) begin
      if (!creq) begin
        creq  = ($urandom_range(0, 3) != 0);
        cwe   = 1'($urandom_range(0, 1));
        cop   = 3'($urandom_range(0, 7));
        caddr = 17'($urandom_range(0, 63));
        cwd   = $urandom;
      end
      if (!dreq) begin
        dreq  = ($urandom_range(0, 1) != 0);
        dwe   = 1'($urandom_range(0, 1));
        daddr = 15'($urandom_range(0, 15));
        dbe   = 4'($urandom_range(0, 15));
        dwd   = $urandom;
      end
      cyc(creq, cwe, cop, caddr, cwd, dreq, dwe, daddr, dbe, dwd);
      if (mdl_cgnt) creq = 1'b0;
      if (mdl_dgnt) dreq = 1'b0;
    end
    idle();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
